seg_scan_ctrl: RTL

Time-multiplexing scheduler that shares one 4-bit code path (S3..S0 into the c0c6 segment decoder) between NDIG seven-segment digits. Holds a double-buffered register file of per-digit codes, writable through a simple write port with a commit handshake. Rotates through the digits with a blanking gap between them to prevent ghosting. Sits between the code-generation logic (modSaidas) and the display pins.

---
 rtl/seg_pkg.sv | 8 +
 rtl/seg_regfile.sv | 45 ++++
 rtl/seg_scan_ctrl.sv | 84 ++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared types and helpers for the segment scan controller
package seg_pkg;
  localparam int CODE_W = 4;
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;
  function automatic int cnt_w(int p, int b);
    return $clog2((p > b ? p : b) + 1);
  endfunction
endpackage

// File: rtl/seg_regfile.sv
// seg_regfile: double-buffered per-digit code store with commit handshake
module seg_regfile import seg_pkg::*; #(
  parameter int NDIG = 4,
  localparam int IW = $clog2(NDIG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [CODE_W-1:0] wr_data,
  input  logic              commit,
  input  logic              idle,
  input  logic              boundary,
  input  logic [IW-1:0]     rd_idx,
  output logic [CODE_W-1:0] rd_data,
  output logic              wr_ready
);
  logic [CODE_W-1:0] shadow_q [NDIG];
  logic [CODE_W-1:0] shadow_d [NDIG];
  logic [CODE_W-1:0] active_q [NDIG];
  logic [CODE_W-1:0] active_d [NDIG];
  logic ready_q, ready_d, take, copy;
  always_comb begin
    take = commit & ready_q;
    copy = (boundary & (take | ~ready_q)) | (idle & ~ready_q);
    // copy takes shadow_d so a write in the commit cycle is included
    for (int i = 0; i < NDIG; i++) begin
      shadow_d[i] = (wr_en && ready_q && wr_addr == 3'(i)) ? wr_data : shadow_q[i];
      active_d[i] = copy ? shadow_d[i] : active_q[i];
    end
    ready_d = copy | (ready_q & ~commit);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      ready_q  <= 1'b1;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      ready_q  <= ready_d;
    end
  assign rd_data  = active_q[rd_idx];
  assign wr_ready = ready_q;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed seven-segment digit scanner with blanking gaps
module seg_scan_ctrl import seg_pkg::*; #(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [CODE_W-1:0] wr_data,
  input  logic              commit,
  output logic              wr_ready,
  output logic [CODE_W-1:0] s_code,
  output logic              code_valid,
  output logic [NDIG-1:0]   dig_en,
  output logic              frame_done
);
  localparam int IW = $clog2(NDIG);
  localparam int CW = cnt_w(PRESCALE, BLANK);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CODE_W-1:0] s_code_q, s_code_d, rd_data;
  logic [NDIG-1:0] dig_en_q, dig_en_d;
  logic code_valid_q, code_valid_d, frame_done_q, frame_done_d, boundary, last;
  seg_regfile #(.NDIG(NDIG)) u_rf (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .idle(state_q == S_IDLE), .boundary(boundary), .rd_idx(idx_d),
    .rd_data(rd_data), .wr_ready(wr_ready)
  );
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q - 1'b1;
    boundary = 1'b0;
    last     = cnt_q == '0;
    if (!enable) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == S_IDLE) begin
      state_d = S_BLANK;
      idx_d   = '0;
      cnt_d   = CW'(BLANK - 1);
    end else if (last && state_q == S_BLANK) begin
      state_d = S_SHOW;
      cnt_d   = CW'(PRESCALE - 1);
    end else if (last) begin
      state_d  = S_BLANK;
      cnt_d    = CW'(BLANK - 1);
      boundary = idx_q == IW'(NDIG - 1);
      idx_d    = boundary ? '0 : idx_q + 1'b1;
    end
    // outputs are registered from the next-state view so they align with the state
    code_valid_d = state_d == S_SHOW;
    s_code_d     = code_valid_d ? rd_data : '0;
    dig_en_d     = code_valid_d ? {{(NDIG-1){1'b0}}, 1'b1} << idx_d : '0;
    frame_done_d = boundary;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      s_code_q     <= '0;
      code_valid_q <= 1'b0;
      dig_en_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      s_code_q     <= s_code_d;
      code_valid_q <= code_valid_d;
      dig_en_q     <= dig_en_d;
      frame_done_q <= frame_done_d;
    end
  assign s_code     = s_code_q;
  assign code_valid = code_valid_q;
  assign dig_en     = dig_en_q;
  assign frame_done = frame_done_q;
endmodule
